// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: stall bus layout,
// address width, stage indices and the arbiter/branch FSM state encodings.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int ADDR_W  = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Stage positions on the stall bus
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  // A stall raised by a stage freezes that stage and everything upstream of it
  localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_FROM_IF  = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_FROM_ID  = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_FROM_EX  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_FROM_MEM = 6'b011111;

  localparam logic [ADDR_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_IF   = 2'd1,
    A_MEM  = 2'd2
  } arb_state_t;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_PEND = 1'b1
  } br_state_t;

endpackage

// File: rtl/pipe_ctrl_mem_port_arb.sv
// Memory-port arbiter between IF fetch and MEM load/store. MEM normally wins,
// but IF is forced through once it has been denied STARVE_LIMIT times in a row.
// A grant is held until mem_done and is always followed by an idle cycle.
module pipe_ctrl_mem_port_arb
  import pipe_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_mem_req,
  input  logic mem_mem_req,
  input  logic mem_done,
  output logic if_mem_gnt,
  output logic mem_mem_gnt,
  output logic if_stall,
  output logic mem_stall
);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_if_starved;
  logic             w_enter_if;

  assign w_if_starved = (r_starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign w_enter_if   = (r_state == A_IDLE) && (w_state_next == A_IF);

  // Grants follow the state directly; nothing is granted while reset is held
  assign if_mem_gnt  = rst && (r_state == A_IF);
  assign mem_mem_gnt = rst && (r_state == A_MEM);

  // A requester is waiting unless it owns the port and the access completes now
  assign if_stall  = rst && if_mem_req  && !(if_mem_gnt  && mem_done);
  assign mem_stall = rst && mem_mem_req && !(mem_mem_gnt && mem_done);

  // Next-state selection: MEM first unless IF is starved, grants run to mem_done
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      A_IDLE: begin
        if (mem_mem_req && !(if_mem_req && w_if_starved)) begin
          w_state_next = A_MEM;
        end else if (if_mem_req) begin
          w_state_next = A_IF;
        end
      end
      A_IF, A_MEM: begin
        if (mem_done) begin
          w_state_next = A_IDLE;
        end
      end
      default: w_state_next = A_IDLE;
    endcase
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= A_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Starvation counter: counts denied IF cycles, saturates, clears when IF wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (w_enter_if) begin
      r_starve_cnt <= '0;
    end else if (if_mem_req && !if_mem_gnt && (r_starve_cnt != {CNT_W{1'b1}})) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests into the stall bus, hosts the
// memory-port arbiter and runs the branch-redirect FSM. A taken branch that
// arrives while IF is stalled is parked until IF can advance; meanwhile IF/ID
// is flushed every cycle so wrong-path fetches never reach decode.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_stall_req,
  input  logic              ex_stall_req,
  input  logic              if_mem_req,
  input  logic              mem_mem_req,
  input  logic              mem_done,
  input  logic              id_b_flag,
  input  logic [ADDR_W-1:0] id_b_target,
  input  logic              ex_b_flag,
  input  logic [ADDR_W-1:0] ex_b_target,
  output logic              if_mem_gnt,
  output logic              mem_mem_gnt,
  output logic [STALL_W-1:0] stall,
  output logic              flush_if_id,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc
);

  logic              w_if_stall;
  logic              w_mem_stall;
  logic              w_branch;
  logic [ADDR_W-1:0] w_branch_target;
  logic              w_if_blocked;

  br_state_t         r_br_state;
  br_state_t         w_br_state_next;
  logic [ADDR_W-1:0] r_pend_pc;
  logic [ADDR_W-1:0] w_pend_pc_next;
  logic              r_pend_src;
  logic              w_pend_src_next;
  logic              w_flush;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_pc;

  pipe_ctrl_mem_port_arb #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .if_mem_req  (if_mem_req),
    .mem_mem_req (mem_mem_req),
    .mem_done    (mem_done),
    .if_mem_gnt  (if_mem_gnt),
    .mem_mem_gnt (mem_mem_gnt),
    .if_stall    (w_if_stall),
    .mem_stall   (w_mem_stall)
  );

  // Stall merge: the most downstream requester decides the pattern
  always_comb begin
    stall = STALL_NONE;
    if (!rst) begin
      stall = STALL_NONE;
    end else if (w_mem_stall) begin
      stall = STALL_FROM_MEM;
    end else if (ex_stall_req) begin
      stall = STALL_FROM_EX;
    end else if (id_stall_req) begin
      stall = STALL_FROM_ID;
    end else if (w_if_stall) begin
      stall = STALL_FROM_IF;
    end
  end

  // EX holds the older instruction, so its branch overrides one resolved in ID
  assign w_branch        = ex_b_flag || id_b_flag;
  assign w_branch_target = ex_b_flag ? ex_b_target : id_b_target;
  assign w_if_blocked    = (stall[STG_IF] == STOP);

  // Branch FSM next-state and outputs; redirect fires only when IF can take it
  always_comb begin
    w_br_state_next = r_br_state;
    w_pend_pc_next  = r_pend_pc;
    w_pend_src_next = r_pend_src;
    w_flush         = 1'b0;
    w_redirect      = 1'b0;
    w_redirect_pc   = ZERO_WORD;
    unique case (r_br_state)
      B_IDLE: begin
        if (w_branch) begin
          w_flush = 1'b1;
          if (!w_if_blocked) begin
            w_redirect    = 1'b1;
            w_redirect_pc = w_branch_target;
          end else begin
            w_pend_pc_next  = w_branch_target;
            w_pend_src_next = ex_b_flag;
            w_br_state_next = B_PEND;
          end
        end
      end
      B_PEND: begin
        w_flush = 1'b1;
        if (!w_if_blocked) begin
          // Parked redirect goes out now; any branch flag this cycle is wrong-path
          w_redirect      = 1'b1;
          w_redirect_pc   = r_pend_pc;
          w_br_state_next = B_IDLE;
        end else if (ex_b_flag && !r_pend_src) begin
          // An EX branch is older than a parked ID branch and supersedes it
          w_pend_pc_next  = ex_b_target;
          w_pend_src_next = 1'b1;
        end
      end
      default: w_br_state_next = B_IDLE;
    endcase
  end

  assign flush_if_id = rst && w_flush;
  assign redirect    = rst && w_redirect;
  assign redirect_pc = rst ? w_redirect_pc : ZERO_WORD;

  // Branch FSM state and parked target
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_br_state <= B_IDLE;
      r_pend_pc  <= ZERO_WORD;
      r_pend_src <= 1'b0;
    end else begin
      r_br_state <= w_br_state_next;
      r_pend_pc  <= w_pend_pc_next;
      r_pend_src <= w_pend_src_next;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations plus a randomized run, all checked against a behavioural model.
module tb_pipe_ctrl;

  localparam int LIMIT   = 4;
  localparam int CNT_MAX = 7;

  logic        clk;
  logic        rst;
  logic        id_stall_req, ex_stall_req, if_mem_req, mem_mem_req, mem_done;
  logic        id_b_flag, ex_b_flag;
  logic [31:0] id_b_target, ex_b_target;
  logic        if_mem_gnt, mem_mem_gnt, flush_if_id, redirect;
  logic [5:0]  stall;
  logic [31:0] redirect_pc;

  pipe_ctrl #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_stall_req (id_stall_req),
    .ex_stall_req (ex_stall_req),
    .if_mem_req   (if_mem_req),
    .mem_mem_req  (mem_mem_req),
    .mem_done     (mem_done),
    .id_b_flag    (id_b_flag),
    .id_b_target  (id_b_target),
    .ex_b_flag    (ex_b_flag),
    .ex_b_target  (ex_b_target),
    .if_mem_gnt   (if_mem_gnt),
    .mem_mem_gnt  (mem_mem_gnt),
    .stall        (stall),
    .flush_if_id  (flush_if_id),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural model state: who owns the port, how long IF has waited,
  // and whether a redirect is parked.
  int          m_owner;      // 0 = nobody, 1 = IF, 2 = MEM
  int          m_starve;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  bit          m_pend_ex;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_in(input bit r, input bit ids, input bit exs, input bit ifr, input bit mr,
                        input bit dn, input bit idb, input logic [31:0] idt,
                        input bit exb, input logic [31:0] ext);
    rst = r; id_stall_req = ids; ex_stall_req = exs; if_mem_req = ifr; mem_mem_req = mr;
    mem_done = dn; id_b_flag = idb; id_b_target = idt; ex_b_flag = exb; ex_b_target = ext;
  endtask

  function automatic bit if_blocked_now();
    bit gi, gm, mem_wait, if_wait;
    gi = (m_owner == 1);
    gm = (m_owner == 2);
    mem_wait = mem_mem_req && !(gm && mem_done);
    if_wait  = if_mem_req && !(gi && mem_done);
    return rst && (mem_wait || ex_stall_req || id_stall_req || if_wait);
  endfunction

  // Compare every DUT output against the model for the current inputs
  task automatic eval_cycle();
    logic [5:0]  e_stall;
    bit          e_ig, e_mg, e_fl, e_rd, blocked, br;
    logic [31:0] e_pc, tgt;
    int          top;
    #1;
    e_stall = 6'd0; e_ig = 0; e_mg = 0; e_fl = 0; e_rd = 0; e_pc = 32'd0;
    if (rst) begin
      e_ig = (m_owner == 1);
      e_mg = (m_owner == 2);
      top = 0;
      if (if_mem_req && !(e_ig && mem_done)) top = 2;
      if (id_stall_req) top = 3;
      if (ex_stall_req) top = 4;
      if (mem_mem_req && !(e_mg && mem_done)) top = 5;
      e_stall = 6'((1 << top) - 1);
      blocked = if_blocked_now();
      br  = ex_b_flag || id_b_flag;
      tgt = ex_b_flag ? ex_b_target : id_b_target;
      if (m_pend) begin
        e_fl = 1;
        if (!blocked) begin e_rd = 1; e_pc = m_pend_pc; end
      end else if (br) begin
        e_fl = 1;
        if (!blocked) begin e_rd = 1; e_pc = tgt; end
      end
    end
    chk("stall", {26'd0, stall}, {26'd0, e_stall});
    chk("if_mem_gnt", {31'd0, if_mem_gnt}, {31'd0, e_ig});
    chk("mem_mem_gnt", {31'd0, mem_mem_gnt}, {31'd0, e_mg});
    chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, e_fl});
    chk("redirect", {31'd0, redirect}, {31'd0, e_rd});
    chk("redirect_pc", redirect_pc, e_pc);
  endtask

  // Advance the model by one clock with the current inputs, then wait for it
  task automatic adv();
    bit blocked, gi;
    if (!rst) begin
      m_owner = 0; m_starve = 0; m_pend = 0; m_pend_pc = 32'd0; m_pend_ex = 0;
    end else begin
      blocked = if_blocked_now();
      gi = (m_owner == 1);
      if (m_pend) begin
        if (!blocked) m_pend = 0;
        else if (ex_b_flag && !m_pend_ex) begin m_pend_pc = ex_b_target; m_pend_ex = 1; end
      end else if ((ex_b_flag || id_b_flag) && blocked) begin
        m_pend = 1;
        m_pend_pc = ex_b_flag ? ex_b_target : id_b_target;
        m_pend_ex = ex_b_flag;
      end
      if (m_owner == 0) begin
        if (mem_mem_req && !(if_mem_req && m_starve >= LIMIT)) begin
          m_owner = 2;
          if (if_mem_req && m_starve < CNT_MAX) m_starve++;
        end else if (if_mem_req) begin
          m_owner = 1;
          m_starve = 0;
        end
      end else begin
        if (if_mem_req && !gi && m_starve < CNT_MAX) m_starve++;
        if (mem_done) m_owner = 0;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
    eval_cycle();
    adv();
  endtask

  logic [5:0] exp_mg;
  logic [5:0] exp_ig;

  initial begin
    m_owner = 0; m_starve = 0; m_pend = 0; m_pend_pc = 32'd0; m_pend_ex = 0;
    set_in(0, 1, 1, 1, 1, 1, 1, 32'h11, 1, 32'h22);
    @(negedge clk);

    // Reset held with every request active: nothing may leak out
    for (int i = 0; i < 2; i++) begin
      eval_cycle();
      chk("rst_stall", {26'd0, stall}, 32'd0);
      chk("rst_gnts", {30'd0, if_mem_gnt, mem_mem_gnt}, 32'd0);
      chk("rst_redirect", {31'd0, redirect}, 32'd0);
      chk("rst_flush", {31'd0, flush_if_id}, 32'd0);
      adv();
    end

    // Both requesters constant, every access completes at once:
    // MEM wins twice while IF's wait count climbs to the limit, then IF is forced
    exp_mg = 6'b001010;
    exp_ig = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      set_in(1, 0, 0, 1, 1, 1, 0, 32'd0, 0, 32'd0);
      eval_cycle();
      chk("starve_mem_gnt", {31'd0, mem_mem_gnt}, {31'd0, exp_mg[i]});
      chk("starve_if_gnt", {31'd0, if_mem_gnt}, {31'd0, exp_ig[i]});
      if (i == 0) chk("mem_wait_stall", {26'd0, stall}, 32'h1F);
      adv();
    end
    reset_cycle();

    // Unblocked branch: EX beats ID, redirect in the same cycle
    set_in(1, 0, 0, 0, 0, 0, 1, 32'h999, 1, 32'h100);
    eval_cycle();
    chk("br_redirect", {31'd0, redirect}, 32'd1);
    chk("br_pc", redirect_pc, 32'h100);
    chk("br_flush", {31'd0, flush_if_id}, 32'd1);
    adv();
    set_in(1, 0, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
    eval_cycle();
    chk("br_quiet", {31'd0, redirect}, 32'd0);
    adv();

    // Stall priority between ID, EX and MEM requesters
    set_in(1, 1, 1, 0, 0, 0, 0, 32'd0, 0, 32'd0);
    eval_cycle();
    chk("stall_id_ex", {26'd0, stall}, 32'h0F);
    adv();
    set_in(1, 1, 1, 0, 1, 0, 0, 32'd0, 0, 32'd0);
    eval_cycle();
    chk("stall_mem", {26'd0, stall}, 32'h1F);
    adv();
    reset_cycle();

    // Branch parked under an IF stall, superseded by an older EX branch
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: set_in(1, 0, 0, 1, 0, 0, 1, 32'h200, 0, 32'd0);
        1: set_in(1, 0, 0, 1, 0, 0, 0, 32'd0, 1, 32'h300);
        2: set_in(1, 0, 0, 1, 0, 0, 0, 32'd0, 0, 32'd0);
        3: set_in(1, 0, 0, 1, 0, 1, 0, 32'd0, 0, 32'd0);
        default: set_in(1, 0, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
      endcase
      eval_cycle();
      chk("pend_flush", {31'd0, flush_if_id}, {31'd0, (i < 4)});
      chk("pend_redirect", {31'd0, redirect}, {31'd0, (i == 3)});
      if (i == 3) chk("pend_pc", redirect_pc, 32'h300);
      adv();
    end
    reset_cycle();

    // Reset while a redirect is parked and MEM owns the port
    set_in(1, 0, 0, 1, 1, 0, 1, 32'h444, 0, 32'd0);
    eval_cycle();
    adv();
    set_in(1, 0, 0, 1, 1, 0, 0, 32'd0, 0, 32'd0);
    eval_cycle();
    chk("abort_pre_gnt", {31'd0, mem_mem_gnt}, 32'd1);
    chk("abort_pre_flush", {31'd0, flush_if_id}, 32'd1);
    adv();
    set_in(0, 0, 0, 1, 1, 0, 0, 32'd0, 0, 32'd0);
    eval_cycle();
    chk("abort_rst_outs", {26'd0, stall}, 32'd0);
    chk("abort_rst_gnt", {30'd0, if_mem_gnt, mem_mem_gnt}, 32'd0);
    adv();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
      eval_cycle();
      chk("abort_no_redirect", {31'd0, redirect}, 32'd0);
      chk("abort_no_gnt", {30'd0, if_mem_gnt, mem_mem_gnt}, 32'd0);
      adv();
    end

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      set_in(($urandom_range(0, 39) != 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 4) == 0), $urandom(),
             ($urandom_range(0, 5) == 0), $urandom());
      eval_cycle();
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
